// File: rtl/mem_order_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_order_arbiter_if
//
// Purpose:
//   Bundles everything between the Mem sub-SICs, the order arbiter and the
//   single data-memory port into one interface.
//
// Signals:
//   head_id      issue id of the oldest in-flight instruction (age reference)
//   sic_req      per-SIC lock request
//   sic_req_id   per-SIC req_issue_id, packed NUM_SICS x ID_WIDTH
//   sic_release  per-SIC release_lock
//   sic_addr     per-SIC word address, packed NUM_SICS x 30
//   sic_wdata    per-SIC write data, packed NUM_SICS x 32
//   sic_wen      per-SIC write enable
//   sic_grant    one-hot grant back to the SICs
//   mem_addr     word address to data memory
//   mem_wdata    write data to data memory
//   mem_wen      data memory write strobe
//   mem_rdata_in combinational read data from data memory
//   sic_rdata    read data broadcast to all SICs
//   busy         lock currently held
//
// Modports:
//   master  the requesting side (SICs plus memory read data)
//   slave   the arbiter itself
// ----------------------------------------------------------------------------
interface mem_order_arbiter_if #(
  parameter int NUM_SICS = 4,
  parameter int ID_WIDTH = 8
);

  logic [ID_WIDTH-1:0]          head_id;
  logic [NUM_SICS-1:0]          sic_req;
  logic [NUM_SICS*ID_WIDTH-1:0] sic_req_id;
  logic [NUM_SICS-1:0]          sic_release;
  logic [NUM_SICS*30-1:0]       sic_addr;
  logic [NUM_SICS*32-1:0]       sic_wdata;
  logic [NUM_SICS-1:0]          sic_wen;
  logic [NUM_SICS-1:0]          sic_grant;
  logic [29:0]                  mem_addr;
  logic [31:0]                  mem_wdata;
  logic                         mem_wen;
  logic [31:0]                  mem_rdata_in;
  logic [31:0]                  sic_rdata;
  logic                         busy;

  modport master (
    output head_id,
    output sic_req,
    output sic_req_id,
    output sic_release,
    output sic_addr,
    output sic_wdata,
    output sic_wen,
    output mem_rdata_in,
    input  sic_grant,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wen,
    input  sic_rdata,
    input  busy
  );

  modport slave (
    input  head_id,
    input  sic_req,
    input  sic_req_id,
    input  sic_release,
    input  sic_addr,
    input  sic_wdata,
    input  sic_wen,
    input  mem_rdata_in,
    output sic_grant,
    output mem_addr,
    output mem_wdata,
    output mem_wen,
    output sic_rdata,
    output busy
  );

endinterface

// File: rtl/mem_order_arbiter.sv
// ----------------------------------------------------------------------------
// mem_order_arbiter
//
// Purpose:
//   Owns the single data-memory port downstream of the Mem sub-SICs. While
//   idle it picks the requesting SIC with the oldest issue id (relative to
//   head_id, modulo 2^ID_WIDTH, ties to the lowest index), locks onto it, and
//   then muxes that SIC's request onto the memory. An access completes in the
//   cycle its grant is high; read data is broadcast to every SIC.
//
// Ports:
//   clk                clock
//   rst                asynchronous, active-high reset
//   arb_if (slave)     SIC lock/memory requests, grants, memory port, busy
//   perf_accesses      (MEM_ARB_PERF_EN only) cycles with a grant, saturating
//   perf_stall_cycles  (MEM_ARB_PERF_EN only) cycles with a request but no
//                      grant, saturating
//
// Configuration:
//   Define MEM_ARB_PERF_EN to add the two 32-bit performance counters. With
//   the macro undefined the counters and their ports do not exist.
// ----------------------------------------------------------------------------
module mem_order_arbiter #(
  parameter int NUM_SICS = 4,
  parameter int ID_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  mem_order_arbiter_if.slave  arb_if
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_accesses,
  output logic [31:0]         perf_stall_cycles
`else
`endif
);

  localparam int IDX_W = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;

  logic [ID_WIDTH-1:0] age [NUM_SICS];
  logic                winValid;
  logic [IDX_W-1:0]    winIdx;
  logic [ID_WIDTH-1:0] winAge;

  logic                ownerReq;
  logic [NUM_SICS-1:0] grant;
  logic [29:0]         memAddr;
  logic [31:0]         memWdata;
  logic                memWen;
  logic [31:0]         rdata;
  logic                busy;

  // Age-ordered select. Subtracting head_id maps every in-flight id onto a
  // distance from the oldest instruction, so ids that wrapped past the top of
  // the id space still sort correctly. A strict less-than keeps the first
  // (lowest index) SIC on equal ages.
  always_comb begin
    winValid = 1'b0;
    winIdx   = '0;
    winAge   = '0;
    for (int i = 0; i < NUM_SICS; i++) begin
      age[i] = arb_if.sic_req_id[i*ID_WIDTH +: ID_WIDTH] - arb_if.head_id;
      if (arb_if.sic_req[i] && (!winValid || (age[i] < winAge))) begin
        winValid = 1'b1;
        winIdx   = IDX_W'(i);
        winAge   = age[i];
      end
    end
  end

  // State and owner registers. Reset is asynchronous so that a grant in
  // progress disappears the moment reset asserts, never completing a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Next-state and output logic. Outputs sit at zero while idle; once locked,
  // the grant follows the owner's live request so a dropped request (abort)
  // never produces an access. Both release and abort hand the port back at
  // the next edge; non-owners simply keep requesting until then.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ownerReq = 1'b0;
    grant    = '0;
    memAddr  = '0;
    memWdata = '0;
    memWen   = 1'b0;
    rdata    = '0;
    busy     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (winValid) begin
          state_d = LOCKED;
          owner_d = winIdx;
        end
      end

      LOCKED: begin
        busy           = 1'b1;
        ownerReq       = arb_if.sic_req[owner_q];
        grant[owner_q] = ownerReq;
        memAddr        = arb_if.sic_addr[owner_q*30 +: 30];
        memWdata       = arb_if.sic_wdata[owner_q*32 +: 32];
        memWen         = ownerReq & arb_if.sic_wen[owner_q];
        rdata          = arb_if.mem_rdata_in;
        if (!ownerReq || arb_if.sic_release[owner_q]) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign arb_if.sic_grant = grant;
  assign arb_if.mem_addr  = memAddr;
  assign arb_if.mem_wdata = memWdata;
  assign arb_if.mem_wen   = memWen;
  assign arb_if.sic_rdata = rdata;
  assign arb_if.busy      = busy;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perfAcc_q, perfAcc_d;
  logic [31:0] perfStall_q, perfStall_d;

  // Saturating counters: one counts cycles that move data, the other counts
  // cycles where someone is asking but nobody holds a grant.
  always_comb begin
    perfAcc_d   = perfAcc_q;
    perfStall_d = perfStall_q;
    if ((|grant) && (perfAcc_q != 32'hFFFF_FFFF)) begin
      perfAcc_d = perfAcc_q + 32'd1;
    end
    if ((|arb_if.sic_req) && !(|grant) && (perfStall_q != 32'hFFFF_FFFF)) begin
      perfStall_d = perfStall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfAcc_q   <= '0;
      perfStall_q <= '0;
    end else begin
      perfAcc_q   <= perfAcc_d;
      perfStall_q <= perfStall_d;
    end
  end

  assign perf_accesses     = perfAcc_q;
  assign perf_stall_cycles = perfStall_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_order_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_order_arbiter
//
// Purpose:
//   Self-checking bench for mem_order_arbiter. Each SIC is modelled as a
//   pending request that holds req (and release_lock) until it sees its
//   grant. Expected grants are queued when a request is posted and checked
//   when the arbiter grants.
// ----------------------------------------------------------------------------
module tb_mem_order_arbiter;

  localparam int NUM_SICS = 4;
  localparam int ID_WIDTH = 8;

  typedef struct {
    int          idx;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic [31:0] rdata;
    int          cycle;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_order_arbiter_if #(.NUM_SICS(NUM_SICS), .ID_WIDTH(ID_WIDTH)) arbIf ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perfAccesses;
  logic [31:0] perfStallCycles;
`endif

  mem_order_arbiter #(.NUM_SICS(NUM_SICS), .ID_WIDTH(ID_WIDTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .arb_if            (arbIf)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_accesses     (perfAccesses),
    .perf_stall_cycles (perfStallCycles)
`endif
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  int cycleCnt    = 0;

  logic                pendReq   [NUM_SICS];
  logic [ID_WIDTH-1:0] pendId    [NUM_SICS];
  logic [29:0]         pendAddr  [NUM_SICS];
  logic [31:0]         pendWdata [NUM_SICS];
  logic                pendWen   [NUM_SICS];
  logic [ID_WIDTH-1:0] headId;
  logic [31:0]         memRdata;

  logic                sampledBusy;
  logic [NUM_SICS-1:0] sampledGrant;

  exp_t expQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, observed, expected, cycleCnt);
    end
  endtask

  task automatic post(input int idx, input logic [ID_WIDTH-1:0] id,
                      input logic [29:0] addr, input logic [31:0] wdata,
                      input logic wen);
    pendReq[idx]   = 1'b1;
    pendId[idx]    = id;
    pendAddr[idx]  = addr;
    pendWdata[idx] = wdata;
    pendWen[idx]   = wen;
  endtask

  task automatic expectGrant(input int idx, input int cycle);
    exp_t e;
    e.idx   = idx;
    e.addr  = pendAddr[idx];
    e.wdata = pendWdata[idx];
    e.wen   = pendWen[idx];
    e.rdata = memRdata;
    e.cycle = cycle;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus();
    logic [NUM_SICS-1:0]          req;
    logic [NUM_SICS*ID_WIDTH-1:0] ids;
    logic [NUM_SICS*30-1:0]       addrs;
    logic [NUM_SICS*32-1:0]       wdatas;
    logic [NUM_SICS-1:0]          wens;
    for (int i = 0; i < NUM_SICS; i++) begin
      req[i]                        = pendReq[i];
      ids[i*ID_WIDTH +: ID_WIDTH]   = pendId[i];
      addrs[i*30 +: 30]             = pendAddr[i];
      wdatas[i*32 +: 32]            = pendWdata[i];
      wens[i]                       = pendWen[i];
    end
    arbIf.head_id      = headId;
    arbIf.sic_req      = req;
    arbIf.sic_release  = req;
    arbIf.sic_req_id   = ids;
    arbIf.sic_addr     = addrs;
    arbIf.sic_wdata    = wdatas;
    arbIf.sic_wen      = wens;
    arbIf.mem_rdata_in = memRdata;
  endtask

  // Sample the outputs mid-cycle and score any grant against the queue.
  task automatic monitorCycle();
    exp_t e;
    logic [NUM_SICS-1:0] g;
    g            = arbIf.sic_grant;
    sampledGrant = g;
    sampledBusy  = arbIf.busy;
    checkOutput("grantOnehot", 32'($countones(g) <= 1), 32'd1);
    checkOutput("grantOnlyToReq", 32'(g & ~arbIf.sic_req), 32'd0);
    if (g == '0) begin
      checkOutput("noGrantWen", 32'(arbIf.mem_wen), 32'd0);
    end else if (expQ.size() == 0) begin
      checkOutput("unexpectedGrant", 32'(g), 32'd0);
    end else begin
      e = expQ.pop_front();
      checkOutput("grantIdx", 32'(g), 32'(1 << e.idx));
      checkOutput("grantCycle", 32'(cycleCnt), 32'(e.cycle));
      checkOutput("memAddr", 32'(arbIf.mem_addr), 32'(e.addr));
      checkOutput("memWen", 32'(arbIf.mem_wen), 32'(e.wen));
      if (e.wen) begin
        checkOutput("memWdata", arbIf.mem_wdata, e.wdata);
      end
      checkOutput("sicRdata", arbIf.sic_rdata, e.rdata);
      checkOutput("busyGranted", 32'(arbIf.busy), 32'd1);
    end
    for (int i = 0; i < NUM_SICS; i++) begin
      if (g[i]) pendReq[i] = 1'b0;
    end
  endtask

  task automatic runCycle();
    applyStimulus();
    @(negedge clk);
    monitorCycle();
    cycleCnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    headId   = '0;
    memRdata = '0;
    for (int i = 0; i < NUM_SICS; i++) begin
      pendReq[i]   = 1'b0;
      pendId[i]    = '0;
      pendAddr[i]  = '0;
      pendWdata[i] = '0;
      pendWen[i]   = 1'b0;
    end
    applyStimulus();

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstGrant", 32'(arbIf.sic_grant), 32'd0);
    checkOutput("rstWen", 32'(arbIf.mem_wen), 32'd0);
    checkOutput("rstBusy", 32'(arbIf.busy), 32'd0);
    checkOutput("rstAddr", 32'(arbIf.mem_addr), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single load from SIC1
    $display("[TB] single load");
    headId   = 8'd5;
    memRdata = 32'hDEADBEEF;
    post(1, 8'd5, 30'h10, 32'h0, 1'b0);
    expectGrant(1, cycleCnt + 1);
    runCycle();
    checkOutput("loadBusyReq", 32'(sampledBusy), 32'd0);
    runCycle();
    checkOutput("loadBusyGrant", 32'(sampledBusy), 32'd1);
    runCycle();
    checkOutput("loadIdleAfter", 32'(sampledBusy), 32'd0);
    checkOutput("loadIdleGrant", 32'(sampledGrant), 32'd0);

    // Oldest id first
    $display("[TB] ordering");
    headId   = 8'd7;
    memRdata = 32'h0BAD_F00D;
    post(0, 8'd9, 30'h20, 32'h0, 1'b0);
    post(2, 8'd7, 30'h30, 32'h0, 1'b0);
    c = cycleCnt;
    expectGrant(2, c + 1);
    expectGrant(0, c + 3);
    repeat (5) runCycle();
    checkOutput("orderDrained", 32'(expQ.size()), 32'd0);

    // Ids wrapping past 0xFF
    $display("[TB] wrap-around");
    headId = 8'hFE;
    post(0, 8'h01, 30'h40, 32'h0, 1'b0);
    post(3, 8'hFF, 30'h50, 32'h0, 1'b0);
    c = cycleCnt;
    expectGrant(3, c + 1);
    expectGrant(0, c + 3);
    repeat (5) runCycle();
    checkOutput("wrapDrained", 32'(expQ.size()), 32'd0);

    // Equal ages go to the lower index
    $display("[TB] tie");
    headId = 8'h80;
    post(3, 8'h82, 30'h60, 32'h0, 1'b0);
    post(1, 8'h82, 30'h61, 32'h0, 1'b0);
    c = cycleCnt;
    expectGrant(1, c + 1);
    expectGrant(3, c + 3);
    repeat (5) runCycle();

    // Store from SIC2
    $display("[TB] store");
    headId = 8'd0;
    post(2, 8'd1, 30'h3, 32'h12345678, 1'b1);
    expectGrant(2, cycleCnt + 1);
    repeat (3) runCycle();
    checkOutput("storeDrained", 32'(expQ.size()), 32'd0);

    // Owner drops its request before being granted
    $display("[TB] abort");
    headId = 8'd0;
    post(1, 8'd1, 30'h70, 32'h55AA55AA, 1'b1);
    post(3, 8'd2, 30'h71, 32'h0, 1'b0);
    c = cycleCnt;
    expectGrant(3, c + 3);
    runCycle();
    pendReq[1] = 1'b0;
    runCycle();
    checkOutput("abortGrant", 32'(sampledGrant), 32'd0);
    checkOutput("abortLocked", 32'(sampledBusy), 32'd1);
    runCycle();
    checkOutput("abortIdle", 32'(sampledBusy), 32'd0);
    repeat (2) runCycle();
    checkOutput("abortDrained", 32'(expQ.size()), 32'd0);

    // Asynchronous reset in the middle of a store grant
    $display("[TB] async reset");
    headId = 8'd0;
    post(2, 8'd3, 30'h7, 32'hA5A5A5A5, 1'b1);
    runCycle();
    applyStimulus();
    #2;
    checkOutput("preRstGrant", 32'(arbIf.sic_grant), 32'h4);
    checkOutput("preRstWen", 32'(arbIf.mem_wen), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midRstGrant", 32'(arbIf.sic_grant), 32'd0);
    checkOutput("midRstWen", 32'(arbIf.mem_wen), 32'd0);
    checkOutput("midRstBusy", 32'(arbIf.busy), 32'd0);
    pendReq[2] = 1'b0;
    applyStimulus();
    @(negedge clk);
    rst = 1'b0;
    cycleCnt++;
    @(posedge clk);
    #1;
    memRdata = 32'hCAFE0001;
    post(1, 8'd4, 30'h44, 32'h0, 1'b0);
    expectGrant(1, cycleCnt + 1);
    repeat (3) runCycle();

    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_order_arbiter.md
Name: mem_order_arbiter

Overview:
- Sits directly downstream of the Mem sub-SICs and owns the single data-memory port.
- Collects each SIC's lock request (req, req_issue_id, release_lock) and memory request (addr, wdata, wen).
- Grants the port to exactly one SIC at a time, oldest issue id first, and muxes that SIC's request onto the memory.
- Broadcasts read data back to all SICs; an access completes in the cycle its grant is high.

Parameters:
- NUM_SICS, 4, number of Mem sub-SICs attached.
- ID_WIDTH, 8, width of issue_id; ages are compared modulo 2^ID_WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- head_id  input  ID_WIDTH  issue id of the oldest in-flight instruction; the age reference.
- sic_req  input  NUM_SICS  per-SIC lock request.
- sic_req_id  input  NUM_SICS*ID_WIDTH  per-SIC req_issue_id.
- sic_release  input  NUM_SICS  per-SIC release_lock.
- sic_addr  input  NUM_SICS*30  per-SIC word address.
- sic_wdata  input  NUM_SICS*32  per-SIC write data.
- sic_wen  input  NUM_SICS  per-SIC write enable.
- sic_grant  output  NUM_SICS  one-hot grant, mem_grant of each SIC.
- mem_addr  output  30  word address to data memory.
- mem_wdata  output  32  write data to memory.
- mem_wen  output  1  memory write strobe.
- mem_rdata_in  input  32  combinational read data from memory.
- sic_rdata  output  32  read data broadcast to all SICs.
- busy  output  1  lock currently held.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- State machine has two states:
  - IDLE: no lock held.
  - LOCKED: owner register (index, issue id) valid.
- Reset forces IDLE and owner=0. Outputs at reset: sic_grant=0, mem_wen=0, busy=0. mem_addr, mem_wdata and sic_rdata are don't-care but driven to 0 while idle.
- Arbitration (IDLE, combinational select, registered result):
  - age_i = (sic_req_id[i] - head_id) mod 2^ID_WIDTH.
  - Winner is the requesting SIC with the smallest age; ties go to the lowest index.
  - On the clock edge with any sic_req set: latch the winner as owner and go to LOCKED.
- LOCKED:
  - sic_grant[owner] = sic_req[owner]; all other grants are 0.
  - mem_addr and mem_wdata come from the owner's fields.
  - mem_wen = sic_grant[owner] & sic_wen[owner].
  - sic_rdata = mem_rdata_in.
  - busy = 1.
- Latency: first request sampled in cycle N → grant in cycle N+1 → IDLE in N+2. Earliest next grant is N+3, giving throughput of 1 access per 2 cycles.
- Release: sic_release[owner] & sic_grant[owner] returns to IDLE at the next edge. Release from a non-owner is ignored.
- Abort: if sic_req[owner] drops while LOCKED with no release, no access is made (grant=0, mem_wen=0) and the block returns to IDLE at the next edge.
- A grant is never given to an index whose sic_req is 0 in that cycle.
- Requests from non-owners while LOCKED are held off, since SICs keep req asserted; no queue state is stored.
- Wrap-around: ids crossing 2^ID_WIDTH-1 → 0 are ordered correctly relative to head_id. The supported window is fewer than 2^(ID_WIDTH-1) in-flight ids.
- Reset mid-operation: asserting rst while LOCKED drops the grant immediately (asynchronous), and no write occurs in that cycle.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: adds two outputs, both 32-bit, cleared on reset, saturating at 2^32-1:
  - perf_accesses: increments every cycle with sic_grant nonzero.
  - perf_stall_cycles: increments every cycle where some sic_req is set and no grant is given.
- Not defined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single load: SIC1 req=1, id=5, head_id=5, addr=0x10, wen=0, mem_rdata_in=0xDEADBEEF.
  → sic_grant=0b0010 one cycle later, sic_rdata=0xDEADBEEF, mem_wen=0, IDLE the following cycle.
- Ordering: SIC0 id=9, SIC2 id=7, head_id=7, both req.
  → SIC2 granted first, then SIC0 two cycles later. Never two grant bits high at once.
- Wrap-around: head_id=0xFE, SIC0 id=0x01, SIC3 id=0xFF.
  → SIC3 granted before SIC0.
- Store: SIC2 wen=1, addr=0x3, wdata=0x12345678.
  → In the grant cycle: mem_wen=1, mem_addr=0x3, mem_wdata=0x12345678. mem_wen=0 in all other cycles.
- Abort: SIC1 is owner, then drops req before grant.
  → sic_grant=0, mem_wen=0, IDLE next edge, and a pending SIC3 is granted afterwards.
- Async reset: assert rst mid-grant of a store.
  → sic_grant=0 and mem_wen=0 in the same cycle. After release, the first request is granted with the normal 1-cycle latency.
